monolith_axis_tx_serializer: RTL and testbench

//  TX end of the Monolith streaming path. Buffers whole permutation states from the hash engine
//  in a chunk FIFO, then serializes them word-by-word as an AXI4-Stream master.

---
 rtl/monolith_axis_pkg.sv | 16 +
 rtl/monolith_chunk_fifo.sv | 86 ++++++++
 rtl/monolith_axis_tx_serializer.sv | 107 ++++++++++
 tb/tb_monolith_axis_tx_serializer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/monolith_axis_pkg.sv
// Shared types and defaults for the Monolith AXI4-Stream path.
// Word and permutation geometry, plus the TX read-side state encoding.
package monolith_axis_pkg;

  localparam int unsigned WORD_WIDTH = 31;
  localparam int unsigned PERM_SIZE  = 16;

  typedef logic [WORD_WIDTH-1:0] word_t;
  typedef word_t perm_t [0:PERM_SIZE-1];

  typedef enum logic {
    TX_IDLE,
    TX_SEND
  } tx_state_t;

endpackage

// File: rtl/monolith_chunk_fifo.sv
// Whole-chunk FIFO: every push captures a complete permutation, every pop retires one.
// Reads are word-addressed into the entry at the read pointer.
module monolith_chunk_fifo #(
  parameter int unsigned DATA_WIDTH  = 31,
  parameter int unsigned CHUNK_SIZE  = 16,
  parameter int unsigned CHUNK_COUNT = 4,
  localparam int unsigned PTR_W = $clog2(CHUNK_COUNT),
  localparam int unsigned CNT_W = $clog2(CHUNK_COUNT + 1),
  localparam int unsigned IDX_W = (CHUNK_SIZE > 1) ? $clog2(CHUNK_SIZE) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] push_data [0:CHUNK_SIZE-1],
  input  logic                  push_req,
  input  logic                  pop,
  input  logic [IDX_W-1:0]      rd_word,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output logic [CNT_W-1:0]      pending,
  output logic [CNT_W-1:0]      pending_next
);

  localparam logic [CNT_W-1:0] COUNT_MAX = CNT_W'(CHUNK_COUNT);

  logic [DATA_WIDTH-1:0] mem [0:CHUNK_COUNT-1][0:CHUNK_SIZE-1];

  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] pending_q;
  logic [CNT_W-1:0] pending_d;
  logic             overflow_q;
  logic             push;
  logic             pop_ok;

  // Full is judged on the registered count, so a same-cycle pop never frees room for a push.
  assign full   = (pending_q == COUNT_MAX);
  assign empty  = (pending_q == '0);
  assign push   = push_req && !full;
  assign pop_ok = pop && !empty;

  always_comb begin
    pending_d = pending_q;
    unique case ({push, pop_ok})
      2'b10:   pending_d = pending_q + CNT_W'(1);
      2'b01:   pending_d = pending_q - CNT_W'(1);
      default: pending_d = pending_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (push_req && full) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = 0; i < int'(CHUNK_SIZE); i++) begin
        mem[wr_ptr_q][i] <= push_data[i];
      end
    end
  end

  assign rd_data      = mem[rd_ptr_q][rd_word];
  assign pending      = pending_q;
  assign pending_next = pending_d;
  assign overflow     = overflow_q;

endmodule

// File: rtl/monolith_axis_tx_serializer.sv
// TX end of the Monolith stream: buffers whole permutations and emits each one as an
// AXI4-Stream packet, one word per beat, TLAST on the final word.
module monolith_axis_tx_serializer
  import monolith_axis_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = WORD_WIDTH,
  parameter int unsigned CHUNK_SIZE  = PERM_SIZE,
  parameter int unsigned CHUNK_COUNT = 4,
  localparam int unsigned CNT_W  = $clog2(CHUNK_COUNT + 1),
  localparam int unsigned STRB_W = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] chunk_in [0:CHUNK_SIZE-1],
  input  logic                  chunk_write_strobe,
  output logic                  fifo_full,
  output logic [CNT_W-1:0]      chunks_pending,
  output logic                  chunk_overflow,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [STRB_W-1:0]     m_axis_tstrb,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready
);

  localparam int unsigned IDX_W = (CHUNK_SIZE > 1) ? $clog2(CHUNK_SIZE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNK_SIZE - 1);

  tx_state_t state_q;
  tx_state_t state_d;

  logic [IDX_W-1:0]      word_idx_q;
  logic [IDX_W-1:0]      word_idx_d;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [CNT_W-1:0]      pending_next;
  logic                  fifo_empty;
  logic                  sending;
  logic                  beat;
  logic                  last_beat;

  assign sending   = (state_q == TX_SEND);
  assign beat      = sending && m_axis_tready;
  assign last_beat = beat && (word_idx_q == LAST_IDX);

  monolith_chunk_fifo #(
    .DATA_WIDTH  (DATA_WIDTH),
    .CHUNK_SIZE  (CHUNK_SIZE),
    .CHUNK_COUNT (CHUNK_COUNT)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_data    (chunk_in),
    .push_req     (chunk_write_strobe),
    .pop          (last_beat),
    .rd_word      (word_idx_q),
    .rd_data      (rd_data),
    .full         (fifo_full),
    .empty        (fifo_empty),
    .overflow     (chunk_overflow),
    .pending      (chunks_pending),
    .pending_next (pending_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= TX_IDLE;
      word_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
    end
  end

  // Looking at the post-update count lets a strobe into an empty FIFO show valid next cycle,
  // and keeps SEND across a pop when more chunks remain so packets run back-to-back.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TX_IDLE: begin
        if (pending_next != '0) begin
          state_d = TX_SEND;
        end
      end
      TX_SEND: begin
        if (last_beat && (pending_next == '0)) begin
          state_d = TX_IDLE;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    word_idx_d = word_idx_q;
    if (beat) begin
      word_idx_d = last_beat ? '0 : word_idx_q + IDX_W'(1);
    end
  end

  always_comb begin
    m_axis_tvalid = sending;
    m_axis_tdata  = sending ? rd_data : '0;
    m_axis_tstrb  = sending ? '1 : '0;
    m_axis_tlast  = sending && (word_idx_q == LAST_IDX);
  end

endmodule

// File: tb/tb_monolith_axis_tx_serializer.sv
// Directed bench for monolith_axis_tx_serializer: packet framing, stalls, full/overflow,
// push/pop coincidence, pointer wrap and mid-packet reset.
module tb_monolith_axis_tx_serializer;

  localparam int DW = 31;
  localparam int CS = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] chunk_in [0:CS-1];
  logic          chunk_write_strobe = 1'b0;
  logic          fifo_full;
  logic [2:0]    chunks_pending;
  logic          chunk_overflow;
  logic          m_axis_tvalid;
  logic [DW-1:0] m_axis_tdata;
  logic [2:0]    m_axis_tstrb;
  logic          m_axis_tlast;
  logic          m_axis_tready = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  monolith_axis_tx_serializer dut (
    .clk                (clk),
    .reset              (reset),
    .chunk_in           (chunk_in),
    .chunk_write_strobe (chunk_write_strobe),
    .fifo_full          (fifo_full),
    .chunks_pending     (chunks_pending),
    .chunk_overflow     (chunk_overflow),
    .m_axis_tvalid      (m_axis_tvalid),
    .m_axis_tdata       (m_axis_tdata),
    .m_axis_tstrb       (m_axis_tstrb),
    .m_axis_tlast       (m_axis_tlast),
    .m_axis_tready      (m_axis_tready)
  );

  function automatic logic [DW-1:0] wval(int tag, int i);
    return DW'(tag * 256 + i);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(int tag);
    for (int i = 0; i < CS; i++) chunk_in[i] = wval(tag, i);
  endtask

  task automatic write_chunk(int tag);
    load(tag);
    chunk_write_strobe = 1'b1;
    tick();
    chunk_write_strobe = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({m_axis_tvalid, m_axis_tlast} !== 2'b00) begin
      n_bad++; $display("FAIL reset_valid_last: got %b want 00", {m_axis_tvalid, m_axis_tlast});
    end
    n_cmp++;
    if ({m_axis_tstrb, m_axis_tdata} !== '0) begin
      n_bad++; $display("FAIL reset_strb_data: got %h/%h want 0/0", m_axis_tstrb, m_axis_tdata);
    end
    n_cmp++;
    if ({fifo_full, chunk_overflow, chunks_pending} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_status: got full=%b ovf=%b pend=%0d want 0/0/0",
               fifo_full, chunk_overflow, chunks_pending);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_packet();
    m_axis_tready = 1'b1;
    write_chunk(0);
    for (int i = 0; i < CS; i++) begin
      n_cmp++;
      if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== {1'b1, i == CS - 1, wval(0, i)}) begin
        n_bad++;
        $display("FAIL single beat %0d: got v=%b l=%b d=%h want v=1 l=%b d=%h", i,
                 m_axis_tvalid, m_axis_tlast, m_axis_tdata, i == CS - 1, wval(0, i));
      end
      tick();
    end
    n_cmp++;
    if ({m_axis_tvalid, chunks_pending} !== 4'b0) begin
      n_bad++;
      $display("FAIL single_idle: got v=%b pend=%0d want 0/0", m_axis_tvalid, chunks_pending);
    end
  endtask

  task automatic test_stall();
    int idx = 0;
    m_axis_tready = 1'b0;
    write_chunk(0);
    for (int c = 0; c < 64 && idx < CS; c++) begin
      m_axis_tready = (c % 2 == 0);
      n_cmp++;
      if ({m_axis_tvalid, m_axis_tlast, m_axis_tstrb, m_axis_tdata} !==
          {1'b1, idx == CS - 1, 3'b111, wval(0, idx)}) begin
        n_bad++;
        $display("FAIL stall cyc %0d: got v=%b l=%b s=%b d=%h want v=1 l=%b s=111 d=%h", c,
                 m_axis_tvalid, m_axis_tlast, m_axis_tstrb, m_axis_tdata, idx == CS - 1,
                 wval(0, idx));
      end
      tick();
      if (m_axis_tready) idx++;
    end
    n_cmp++;
    if (idx !== CS) begin
      n_bad++; $display("FAIL stall_beats: got %0d want %0d", idx, CS);
    end
    n_cmp++;
    if ({m_axis_tvalid, m_axis_tstrb} !== 4'b0) begin
      n_bad++; $display("FAIL stall_idle: got v=%b s=%b want 0/000", m_axis_tvalid, m_axis_tstrb);
    end
  endtask

  task automatic test_full_overflow();
    m_axis_tready = 1'b0;
    for (int k = 0; k < 4; k++) write_chunk(32'h100 + k);
    n_cmp++;
    if ({fifo_full, chunk_overflow, chunks_pending} !== {1'b1, 1'b0, 3'd4}) begin
      n_bad++;
      $display("FAIL full_status: got full=%b ovf=%b pend=%0d want 1/0/4",
               fifo_full, chunk_overflow, chunks_pending);
    end
    write_chunk(32'h1FF);
    n_cmp++;
    if ({fifo_full, chunk_overflow, chunks_pending} !== {1'b1, 1'b1, 3'd4}) begin
      n_bad++;
      $display("FAIL overflow_status: got full=%b ovf=%b pend=%0d want 1/1/4",
               fifo_full, chunk_overflow, chunks_pending);
    end
    m_axis_tready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < CS; i++) begin
        n_cmp++;
        if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !==
            {1'b1, i == CS - 1, wval(32'h100 + k, i)}) begin
          n_bad++;
          $display("FAIL drain pkt %0d beat %0d: got v=%b l=%b d=%h want v=1 l=%b d=%h", k, i,
                   m_axis_tvalid, m_axis_tlast, m_axis_tdata, i == CS - 1,
                   wval(32'h100 + k, i));
        end
        tick();
      end
    end
    n_cmp++;
    if ({m_axis_tvalid, chunks_pending, chunk_overflow} !== {1'b0, 3'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL drain_idle: got v=%b pend=%0d ovf=%b want 0/0/1",
               m_axis_tvalid, chunks_pending, chunk_overflow);
    end
  endtask

  // Streams 'beats' words of chunk 'tag' starting at word 'first', one beat per tick.
  task automatic expect_words(int tag, int first, int beats, string name);
    for (int i = first; i < first + beats; i++) begin
      n_cmp++;
      if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== {1'b1, i == CS - 1, wval(tag, i)}) begin
        n_bad++;
        $display("FAIL %s word %0d: got v=%b l=%b d=%h want v=1 l=%b d=%h", name, i,
                 m_axis_tvalid, m_axis_tlast, m_axis_tdata, i == CS - 1, wval(tag, i));
      end
      tick();
    end
  endtask

  task automatic test_coincide();
    m_axis_tready = 1'b0;
    for (int k = 0; k < 4; k++) write_chunk(32'h200 + k);
    m_axis_tready = 1'b1;
    expect_words(32'h200, 0, CS - 1, "co_a");
    load(32'h2FF);
    chunk_write_strobe = 1'b1;
    expect_words(32'h200, CS - 1, 1, "co_a_last");
    chunk_write_strobe = 1'b0;
    n_cmp++;
    if ({fifo_full, chunks_pending} !== {1'b0, 3'd3}) begin
      n_bad++;
      $display("FAIL full_pop_push: got full=%b pend=%0d want 0/3", fifo_full, chunks_pending);
    end
    expect_words(32'h201, 0, CS, "co_b");
    n_cmp++;
    if (chunks_pending !== 3'd2) begin
      n_bad++; $display("FAIL pend_after_pop: got %0d want 2", chunks_pending);
    end
    expect_words(32'h202, 0, CS - 1, "co_c");
    load(32'h2AA);
    chunk_write_strobe = 1'b1;
    expect_words(32'h202, CS - 1, 1, "co_c_last");
    chunk_write_strobe = 1'b0;
    n_cmp++;
    if (chunks_pending !== 3'd2) begin
      n_bad++; $display("FAIL pop_push_pend: got %0d want 2", chunks_pending);
    end
    expect_words(32'h203, 0, CS, "co_d");
    expect_words(32'h2AA, 0, CS, "co_new");
    n_cmp++;
    if ({m_axis_tvalid, chunks_pending} !== 4'b0) begin
      n_bad++;
      $display("FAIL co_idle: got v=%b pend=%0d want 0/0", m_axis_tvalid, chunks_pending);
    end
  endtask

  task automatic test_stream();
    m_axis_tready = 1'b1;
    for (int s = 0; s < 10 * CS; s++) begin
      if (s % CS == 0) begin
        load(32'h300 + s / CS);
        chunk_write_strobe = 1'b1;
      end else begin
        chunk_write_strobe = 1'b0;
      end
      tick();
      n_cmp++;
      if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata, chunks_pending} !==
          {1'b1, s % CS == CS - 1, wval(32'h300 + s / CS, s % CS), 3'd1}) begin
        n_bad++;
        $display("FAIL stream cyc %0d: got v=%b l=%b d=%h p=%0d want v=1 l=%b d=%h p=1", s,
                 m_axis_tvalid, m_axis_tlast, m_axis_tdata, chunks_pending, s % CS == CS - 1,
                 wval(32'h300 + s / CS, s % CS));
      end
    end
    chunk_write_strobe = 1'b0;
    tick();
    n_cmp++;
    if ({m_axis_tvalid, chunks_pending} !== 4'b0) begin
      n_bad++;
      $display("FAIL stream_idle: got v=%b pend=%0d want 0/0", m_axis_tvalid, chunks_pending);
    end
  endtask

  task automatic test_mid_reset();
    m_axis_tready = 1'b1;
    write_chunk(32'h400);
    expect_words(32'h400, 0, 7, "pre_rst");
    n_cmp++;
    if (m_axis_tdata !== wval(32'h400, 7)) begin
      n_bad++; $display("FAIL pre_rst_beat7: got %h want %h", m_axis_tdata, wval(32'h400, 7));
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({m_axis_tvalid, m_axis_tlast, chunks_pending, chunk_overflow} !== 6'b0) begin
      n_bad++;
      $display("FAIL async_reset: got v=%b l=%b pend=%0d ovf=%b want 0/0/0/0",
               m_axis_tvalid, m_axis_tlast, chunks_pending, chunk_overflow);
    end
    tick();
    reset = 1'b0;
    tick();
    write_chunk(32'h500);
    expect_words(32'h500, 0, CS, "post_rst");
    n_cmp++;
    if ({m_axis_tvalid, chunks_pending} !== 4'b0) begin
      n_bad++;
      $display("FAIL post_rst_idle: got v=%b pend=%0d want 0/0", m_axis_tvalid, chunks_pending);
    end
  endtask

  initial begin
    load(0);
    test_reset();
    test_single_packet();
    test_stall();
    test_full_overflow();
    test_coincide();
    test_stream();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
